// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Holds size codes, the FSM state type and the alignment check.
package dm_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned OFF_W      = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } lsu_state_e;

    // Reserved size and misaligned half/word accesses are rejected without a RAM cycle.
    function automatic logic access_err(input logic [1:0] size, input logic [OFF_W-1:0] offset);
        logic err;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = offset[0];
            SZ_W:    err = |offset;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half lane steering: load extract with sign/zero extension and store merge.
// Purely combinational; the caller supplies the RAM word and the registered request fields.
module dm_lane_align
    import dm_lsu_pkg::*;
(
    input  logic [31:0]      word,
    input  logic [31:0]      wdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [31:0]      load_data,
    output logic [31:0]      store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = word[{offset, 3'b000} +: 8];
        lane_h     = word[{offset[1], 4'b0000} +: 16];
        load_data  = '0;
        store_word = word;
        case (size)
            SZ_B: begin
                load_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
                store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_W: begin
                load_data  = word;
                store_word = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of the 64-word data RAM.
// Sub-word stores are done as read-modify-write; all accesses are one request at a time.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic [31:0]       M_W_Data,
    input  logic [31:0]       M_R_Data
);

    lsu_state_e state_q, state_d;

    logic [OFF_W-1:0]  offset_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [31:0]       m_w_data_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_err = access_err(req_size, req_addr[OFF_W-1:0]);
    assign accept  = req_valid && req_ready;

    dm_lane_align u_align (
        .word        (M_R_Data),
        .wdata       (wdata_q),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && req_size == SZ_W) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = rsp_ready ? StIdle : StResp;
            default: state_d = StIdle;
        endcase
    end

    // Write enable decoded from state so an async reset kills it without waiting for a clock.
    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        Mem_Write = (state_q == StWr);
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            offset_q    <= '0;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dm_addr_q   <= '0;
            m_w_data_q  <= '0;
        end else if (accept) begin
            offset_q    <= req_addr[OFF_W-1:0];
            size_q      <= req_size;
            we_q        <= req_we;
            uns_q       <= req_unsigned;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= req_err;
            if (!req_err) begin
                dm_addr_q <= req_addr[ADDR_W+1:2];
                if (req_we && req_size == SZ_W) begin
                    m_w_data_q <= req_wdata;
                end
            end
        end else if (state_q == StRd) begin
            if (we_q) begin
                m_w_data_q <= store_word;
            end else begin
                rsp_rdata_q <= load_data;
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign DM_Addr   = dm_addr_q;
    assign M_W_Data  = m_w_data_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Testbench for dm_lsu: directed plan steps followed by random requests,
// checked against a byte-arithmetic memory model.
module tb_dm_lsu;

    localparam int ADDR_W = 6;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk_dm = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              Mem_Write;
    logic [ADDR_W-1:0] DM_Addr;
    logic [31:0]       M_W_Data;
    logic [31:0]       M_R_Data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram      [WORDS];
    logic [31:0] seed_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];
    logic        ram_load = 1'b1;

    always #5 clk_dm = ~clk_dm;

    dm_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk_dm       (clk_dm),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .Mem_Write    (Mem_Write),
        .DM_Addr      (DM_Addr),
        .M_W_Data     (M_W_Data),
        .M_R_Data     (M_R_Data)
    );

    // RAM: combinational read, write at the clock edge.
    assign M_R_Data = ram[DM_Addr];
    always @(posedge clk_dm) begin
        if (ram_load) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= seed_mem[i];
        end else if (Mem_Write) begin
            ram[DM_Addr] <= M_W_Data;
        end
    end

    task automatic tick();
        @(posedge clk_dm);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for its response, hold it `hold` cycles, then accept it.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] wd, input int hold);
        int          widx, sh, nb, exp_lat, exp_wr, cyc, wr_n;
        logic [31:0] mask, oldw, exp_rd, exp_wd, wr_d;
        logic [5:0]  wr_a, addr1;
        logic        exp_err, we1;
        widx    = int'(a) / 4;
        sh      = (int'(a) % 4) * 8;
        nb      = 1 << sz;
        exp_err = (sz == 2'b11) || ((int'(a) % nb) != 0);
        mask    = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (nb * 8)) - 32'h1);
        oldw    = ref_mem[widx];
        exp_rd  = '0;
        exp_wd  = '0;
        exp_wr  = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd  = (oldw >> sh) & mask;
            if (!uns && exp_rd[nb * 8 - 1]) exp_rd = exp_rd | ~mask;
        end else begin
            exp_lat = (nb == 4) ? 2 : 3;
            exp_wr  = 1;
            exp_wd  = (oldw & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[widx] = exp_wd;
        end

        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr  = a;    req_wdata = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_wdata = $urandom;
        cyc   = 1;
        wr_n  = 0;
        wr_a  = '0;
        wr_d  = '0;
        addr1 = DM_Addr;
        we1   = Mem_Write;
        while (!rsp_valid && cyc < 8) begin
            if (Mem_Write) begin
                wr_n++;
                wr_a = DM_Addr;
                wr_d = M_W_Data;
            end
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("write_count", 32'(wr_n), 32'(exp_wr));
        if (exp_wr != 0) begin
            chk("write_addr", 32'(wr_a), 32'(widx));
            chk("write_data", wr_d, exp_wd);
        end
        if (!exp_err && (!we || nb != 4)) begin
            chk("rd_addr", 32'(addr1), 32'(widx));
            chk("rd_no_write", 32'(we1), 32'd0);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 32'(rsp_err), 32'(exp_err));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_no_write", 32'(Mem_Write), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("back_idle", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rv;
        for (int i = 0; i < WORDS; i++) begin
            seed_mem[i] = $urandom;
            ref_mem[i]  = seed_mem[i];
        end

        // Reset
        rst_n    = 1'b0;
        ram_load = 1'b1;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'd1);
        repeat (3) tick();
        ram_load = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_write", 32'(Mem_Write), 32'd0);
        chk("rst_dm_addr", 32'(DM_Addr), 32'd0);
        chk("rst_m_w_data", M_W_Data, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Directed plan
        do_req(1'b1, 2'b10, 1'b0, 8'h14, 32'h8899_AABB, 0);
        do_req(1'b0, 2'b00, 1'b0, 8'h15, 32'h0, 0);
        do_req(1'b0, 2'b00, 1'b1, 8'h15, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b0, 8'h16, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b1, 8'h14, 32'h0, 0);
        do_req(1'b1, 2'b00, 1'b0, 8'h17, 32'h0000_005A, 0);
        do_req(1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 0);
        do_req(1'b0, 2'b01, 1'b0, 8'h15, 32'h0, 0);
        do_req(1'b1, 2'b10, 1'b0, 8'h16, 32'hDEAD_BEEF, 0);
        do_req(1'b1, 2'b11, 1'b0, 8'h14, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 4);

        // Reset asserted while a byte store is in its write cycle
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr  = 8'h14; req_wdata = 32'h0000_00C3;
        tick();
        req_valid = 1'b0;
        tick();
        chk("wr_cycle_before_reset", 32'(Mem_Write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mem_write_drops", 32'(Mem_Write), 32'd0);
        chk("reset_idle", 32'(req_ready), 32'd1);
        chk("reset_drops_rsp", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_req(1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 0);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            rv = $urandom;
            do_req(rv[0], rv[2:1], rv[3], 8'($urandom_range(0, 255)), $urandom,
                   int'(rv[5:4]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Load/store unit that initiates every access to the 64-word data memory (RAM: Mem_Write, DM_Addr, M_W_Data, M_R_Data).
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake and returns load data or completion over a valid/ready response channel.
- Translates byte and halfword accesses into word accesses; sub-word stores use read-modify-write.
- Sits between the core's memory stage and the RAM.

Parameters:
- ADDR_W, 6, word-address width. The byte address is ADDR_W+2 bits.

Ports:
- clk_dm  in  1  clock; RAM is clocked by the same net.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load when 1.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or reserved size.
- Mem_Write  out  1  RAM write enable, sampled at posedge clk_dm.
- DM_Addr  out  ADDR_W  RAM word address.
- M_W_Data  out  32  RAM write data.
- M_R_Data  in  32  RAM combinational read data.

Behaviour:
- Reset:
  - Registers go to their reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, Mem_Write=0, DM_Addr=0, M_W_Data=0.
  - req_ready=1 while rst_n=0.
- req_ready = (state==IDLE).
- A request is accepted at a posedge with req_valid&&req_ready. The unit registers addr, size, we, unsigned and wdata.
- Alignment:
  - Half requires addr[0]==0.
  - Word requires addr[1:0]==0.
  - Size 11 is always an error.
  - An error request goes IDLE->RESP with rsp_err=1 and rsp_rdata=0. No RAM cycle is issued.
- States: IDLE, RD, WR, RESP.
  - Load: IDLE->RD->RESP.
  - Word store: IDLE->WR->RESP.
  - Byte/half store: IDLE->RD->WR->RESP.
- RD state:
  - DM_Addr = addr[ADDR_W+1:2] and Mem_Write=0.
  - M_R_Data is captured at the end of the cycle.
  - Load: lane extract then sign/zero extend into rsp_rdata. Byte lane = addr[1:0]; half lane = addr[1].
  - Store: captured word is held for the merge.
- WR state:
  - Mem_Write=1 for exactly one cycle; DM_Addr = word address.
  - M_W_Data = full wdata for a word store, else the captured word with the addressed byte/half lane replaced by wdata[7:0] or wdata[15:0].
- Mem_Write is 1 only in WR. DM_Addr and M_W_Data hold their last values outside RD/WR.
- Latency from accept edge to rsp_valid rising: error 1, load 2, word store 2, sub-word store 3 cycles.
- RESP state:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_valid&&rsp_ready at a posedge, then ->IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Reset mid-operation (rst_n falling in any state):
  - State returns to IDLE immediately and Mem_Write drops combinationally. No RAM write occurs after the reset edge.
  - A pending response is discarded.
- Stores never return data: rsp_rdata=0.

Decomposition:
- Package dm_lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum, helper constant WORD_BYTES=4.
- Sub-module dm_lane_align (combinational):
  - Load extract/extend: inputs word, offset, size, unsigned.
  - Store merge: inputs old word, new data, offset, size.
  - Instantiated once; the FSM stays in dm_lsu.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> req_ready=1, rsp_valid=0, Mem_Write=0, DM_Addr=0, M_W_Data=0.
- Word store to addr 0x14, data 0x8899AABB -> Mem_Write high exactly one cycle with DM_Addr=5, M_W_Data=0x8899AABB. rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Loads of word 5 (contents 0x8899AABB):
  - Signed byte at 0x15 -> 0xFFFFFFAA.
  - Unsigned byte at 0x15 -> 0x000000AA.
  - Signed half at 0x16 -> 0xFFFF8899.
  - Unsigned half at 0x14 -> 0x0000AABB.
  - Each responds 2 cycles after accept.
- Byte store 0x5A at 0x17:
  - RD cycle with DM_Addr=5 and Mem_Write=0.
  - WR cycle with M_W_Data=0x5A99AABB.
  - rsp_valid at cycle 3.
  - Follow-up word load at 0x14 -> 0x5A99AABB.
- Half at 0x15, word at 0x16, size 11 at 0x14 -> each rsp_err=1 one cycle after accept, rsp_rdata=0, Mem_Write never asserted.
- Backpressure and reset:
  - Hold rsp_ready=0 for 4 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
  - Assert rst_n=0 mid-cycle during WR of a byte store to 0x14 -> Mem_Write falls immediately and a word load afterwards returns the unmodified word.
